// File: rtl/sum_4b_if.sv
// sum_4b_if: operand/result bundle for the sum_4b registered adder.
//   A, B  : 4-bit unsigned operands (driven by master)
//   Sum   : registered (A + B) mod 16 (driven by slave)
//   Cout  : registered carry out of bit 3 (driven by slave)
//   Ovf   : registered signed overflow, only with SUM_4B_OVF_EN defined
// Modports: master = operand source / result sink, slave = the adder.
interface sum_4b_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Sum;
  logic       Cout;
`ifdef SUM_4B_OVF_EN
  logic       Ovf;

  modport master (output A, output B, input Sum, input Cout, input Ovf);
  modport slave  (input A, input B, output Sum, output Cout, output Ovf);
`else
  modport master (output A, output B, input Sum, input Cout);
  modport slave  (input A, input B, output Sum, output Cout);
`endif
endinterface

// File: rtl/sum_4b.sv
// sum_4b: registered 4-bit unsigned ripple-carry adder.
// Four full-adder cells feed an output register that loads every clock;
// results appear one cycle after the operands are sampled.
// Ports:
//   clk  : rising-edge clock for the output register
//   rst  : asynchronous active-high reset, clears the outputs
//   bus  : sum_4b_if.slave (A, B in; Sum, Cout [, Ovf] out)
// Optional feature macro: SUM_4B_OVF_EN adds the registered signed
// overflow flag Ovf = c[4] ^ c[3].
module sum_4b (
  input  logic     clk,
  input  logic     rst,
  sum_4b_if.slave  bus
);

  logic [4:0] c;
  logic [3:0] s;
  logic [3:0] sum_d, sum_q;
  logic       cout_d, cout_q;

  // Ripple chain: carry of cell i feeds cell i+1, carry-in of cell 0 is 0.
  always_comb begin
    c    = '0;
    s    = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
      c[i+1] = (bus.A[i] & bus.B[i]) | (c[i] & (bus.A[i] ^ bus.B[i]));
    end
  end

  assign sum_d  = s;
  assign cout_d = c[4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= 4'h0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign bus.Sum  = sum_q;
  assign bus.Cout = cout_q;

`ifdef SUM_4B_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into the sign bit differing from carry out means the signed
  // result left the -8..7 range.
  assign ovf_d = c[4] ^ c[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sum_4b.sv
module tb_sum_4b;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sum_4b_if bus ();

  sum_4b u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer addition of the operands.
  function automatic int ref_sum(input int a, input int b);
    return (a + b) % 16;
  endfunction

  function automatic int ref_cout(input int a, input int b);
    return ((a + b) >= 16) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int a, input int b);
    int sa, sb, r;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r  = sa + sb;
    return ((r > 7) || (r < -8)) ? 1 : 0;
  endfunction

  task automatic drive(input int a, input int b);
    @(negedge clk);
    bus.A = a[3:0];
    bus.B = b[3:0];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(9, 9);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.Sum !== 4'd0 || bus.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got Sum=%0d Cout=%0b, want Sum=0 Cout=0", bus.Sum, bus.Cout);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Sum !== 4'd0 || bus.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got Sum=%0d Cout=%0b, want Sum=0 Cout=0", bus.Sum, bus.Cout);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.Sum !== 4'd2 || bus.Cout !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got Sum=%0d Cout=%0b, want Sum=2 Cout=1", bus.Sum, bus.Cout);
    end
  endtask

  task automatic test_sweep();
    for (int b = 0; b <= 14; b++) begin
      drive(1, b);
      @(posedge clk); #1;
      checks++;
      if (bus.Sum !== 4'(ref_sum(1, b)) || bus.Cout !== 1'(ref_cout(1, b))) begin
        errors++;
        $display("FAIL sweep B=%0d: got Sum=%0d Cout=%0b, want Sum=%0d Cout=%0d",
                 b, bus.Sum, bus.Cout, ref_sum(1, b), ref_cout(1, b));
      end
    end
  endtask

  task automatic test_wrap();
    int pa[2] = '{15, 15};
    int pb[2] = '{1, 15};
    int es[2] = '{0, 14};
    for (int k = 0; k < 2; k++) begin
      drive(pa[k], pb[k]);
      @(posedge clk); #1;
      checks++;
      if (bus.Sum !== 4'(es[k]) || bus.Cout !== 1'b1) begin
        errors++;
        $display("FAIL wrap %0d+%0d: got Sum=%0d Cout=%0b, want Sum=%0d Cout=1",
                 pa[k], pb[k], bus.Sum, bus.Cout, es[k]);
      end
    end
  endtask

  task automatic test_exhaustive();
    int order[256];
    int j, t, a, b, pa, pb;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    pa = -1; pb = -1;
    for (int i = 0; i < 256; i++) begin
      a = order[i] / 16;
      b = order[i] % 16;
      drive(a, b);
      #2;
      if (pa >= 0) begin
        checks++;
        if (bus.Sum !== 4'(ref_sum(pa, pb)) || bus.Cout !== 1'(ref_cout(pa, pb))) begin
          errors++;
          $display("FAIL hold %0d+%0d: got Sum=%0d Cout=%0b, want Sum=%0d Cout=%0d",
                   pa, pb, bus.Sum, bus.Cout, ref_sum(pa, pb), ref_cout(pa, pb));
        end
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.Cout, bus.Sum} !== 5'(a + b)) begin
        errors++;
        $display("FAIL exhaustive %0d+%0d: got {Cout,Sum}=%0d, want %0d",
                 a, b, {bus.Cout, bus.Sum}, a + b);
      end
`ifdef SUM_4B_OVF_EN
      checks++;
      if (bus.Ovf !== 1'(ref_ovf(a, b))) begin
        errors++;
        $display("FAIL exhaustive_ovf %0d+%0d: got Ovf=%0b, want %0d", a, b, bus.Ovf, ref_ovf(a, b));
      end
`endif
      pa = a; pb = b;
    end
  endtask

  task automatic test_async_reset();
    drive(8, 8);
    @(posedge clk); #1;
    checks++;
    if (bus.Sum !== 4'd0 || bus.Cout !== 1'b1) begin
      errors++;
      $display("FAIL stream_pre: got Sum=%0d Cout=%0b, want Sum=0 Cout=1", bus.Sum, bus.Cout);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.Sum !== 4'd0 || bus.Cout !== 1'b0) begin
      errors++;
      $display("FAIL midstream_reset: got Sum=%0d Cout=%0b, want Sum=0 Cout=0", bus.Sum, bus.Cout);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.Cout !== 1'b0) begin
      errors++;
      $display("FAIL release_no_edge: got Cout=%0b, want 0", bus.Cout);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.Sum !== 4'd0 || bus.Cout !== 1'b1) begin
      errors++;
      $display("FAIL midstream_release: got Sum=%0d Cout=%0b, want Sum=0 Cout=1", bus.Sum, bus.Cout);
    end
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(15, 0);
      b = $urandom_range(15, 0);
      drive(a, b);
      @(posedge clk); #1;
      checks++;
      if (bus.Sum !== 4'(ref_sum(a, b)) || bus.Cout !== 1'(ref_cout(a, b))) begin
        errors++;
        $display("FAIL random %0d+%0d: got Sum=%0d Cout=%0b, want Sum=%0d Cout=%0d",
                 a, b, bus.Sum, bus.Cout, ref_sum(a, b), ref_cout(a, b));
      end
    end
  endtask

`ifdef SUM_4B_OVF_EN
  task automatic test_ovf();
    int pa[3] = '{7, 8, 15};
    int pb[3] = '{1, 8, 1};
    int eo[3] = '{1, 1, 0};
    int ec[3] = '{0, 1, 1};
    for (int k = 0; k < 3; k++) begin
      drive(pa[k], pb[k]);
      @(posedge clk); #1;
      checks++;
      if (bus.Ovf !== 1'(eo[k]) || bus.Cout !== 1'(ec[k])) begin
        errors++;
        $display("FAIL ovf %0d+%0d: got Ovf=%0b Cout=%0b, want Ovf=%0d Cout=%0d",
                 pa[k], pb[k], bus.Ovf, bus.Cout, eo[k], ec[k]);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.Ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reset: got Ovf=%0b, want 0", bus.Ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    bus.A  = 4'd0;
    bus.B  = 4'd0;
    test_reset();
    test_sweep();
    test_wrap();
    test_exhaustive();
    test_async_reset();
    test_random();
`ifdef SUM_4B_OVF_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
